// File: rtl/rv32_pkg.sv
// Shared decode-stage types: regfile FSM states and default sizing.
package rv32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    INIT,
    READY
  } rf_state_e;

endpackage

// File: rtl/id_regfile_sb_if.sv
// Decode-side regfile/scoreboard bundle: read ports, issue and writeback.
interface id_regfile_sb_if
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
) ();

  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     hazard;
  logic                     issue_valid;
  logic                     issue_we;
  logic [AW-1:0]            issue_rd;
  logic                     wb_valid;
  logic [AW-1:0]            wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic                     init_done;

  modport master (
    output rd_addr, issue_valid, issue_we, issue_rd,
    output wb_valid, wb_rd, wb_data,
    input  rd_data, rd_busy, hazard, init_done
  );

  modport slave (
    input  rd_addr, issue_valid, issue_we, issue_rd,
    input  wb_valid, wb_rd, wb_data,
    output rd_data, rd_busy, hazard, init_done
  );

endinterface

// File: rtl/rf_bank.sv
// Register storage: one write port, NRD async read ports, x0 hardwired 0.
module rf_bank
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][XLEN-1:0] rdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (raddr[i] != '0) begin
        rdata[i] = regs[raddr[i]];
      end
    end
  end

endmodule

// File: rtl/id_regfile_sb.sv
// Decode regfile + busy scoreboard with clear-on-init FSM.
// Define ID_REGFILE_BYPASS_EN for same-cycle writeback forwarding.
module id_regfile_sb
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
) (
  input logic            clk,
  input logic            rst,
  id_regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  rf_state_e state;
  rf_state_e state_nxt;

  logic [AW-1:0]            cnt;
  logic [NREG-1:0]          busy;
  logic [NREG-1:0]          busy_nxt;
  logic                     ready;
  logic                     in_init;
  logic                     bank_we;
  logic [AW-1:0]            bank_waddr;
  logic [XLEN-1:0]          bank_wdata;
  logic [NRD-1:0][XLEN-1:0] bank_rdata;
  logic [NRD-1:0]           fwd;

  assign ready   = (state == READY) && !rst;
  assign in_init = (state == INIT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= AW'(1);
      busy  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (cnt == LAST) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Set after clear so a same-cycle issue keeps the new writer visible.
  always_comb begin
    busy_nxt = busy;
    if (ready && bus.wb_valid) begin
      busy_nxt[bus.wb_rd] = 1'b0;
    end
    if (ready && bus.issue_valid && bus.issue_we) begin
      busy_nxt[bus.issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = bus.wb_rd;
    bank_wdata = bus.wb_data;
    if (in_init) begin
      bank_we    = 1'b1;
      bank_waddr = cnt;
      bank_wdata = '0;
    end else if (ready) begin
      bank_we    = bus.wb_valid;
    end
  end

  rf_bank #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (bus.rd_addr),
    .rdata (bank_rdata)
  );

  always_comb begin
    fwd = '0;
`ifdef ID_REGFILE_BYPASS_EN
    for (int i = 0; i < NRD; i++) begin
      fwd[i] = ready && bus.wb_valid
            && (bus.wb_rd == bus.rd_addr[i])
            && (bus.rd_addr[i] != '0);
    end
`endif
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rd_data[i] = fwd[i] ? bus.wb_data : bank_rdata[i];
      bus.rd_busy[i] = !rst && !fwd[i] && busy[bus.rd_addr[i]];
    end
  end

  assign bus.hazard    = rst || (state == INIT) || (|bus.rd_busy);
  assign bus.init_done = ready;

endmodule

// File: tb/tb_id_regfile_sb.sv
// Scoreboard bench for id_regfile_sb: directed stimulus, negedge monitor.
module tb_id_regfile_sb;

`ifdef ID_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        hz;
    logic        dn;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  id_regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

  id_regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc
          || (e.chk && (bus.rd_data[0] !== e.d0
                     || bus.rd_data[1] !== e.d1))
          || bus.rd_busy !== e.b
          || bus.hazard !== e.hz
          || bus.init_done !== e.dn) begin
        errors++;
        $display("FAIL %s cyc=%0d got d0=%h d1=%h busy=%b hz=%b done=%b exp d0=%h d1=%h busy=%b hz=%b done=%b",
                 e.name, cyc, bus.rd_data[0], bus.rd_data[1],
                 bus.rd_busy, bus.hazard, bus.init_done,
                 e.d0, e.d1, e.b, e.hz, e.dn);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a0, input logic [4:0] a1,
                       input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wd);
    bus.rd_addr[0]  = a0;
    bus.rd_addr[1]  = a1;
    bus.issue_valid = iv;
    bus.issue_we    = iv;
    bus.issue_rd    = ird;
    bus.wb_valid    = wv;
    bus.wb_rd       = wrd;
    bus.wb_data     = wd;
  endtask

  task automatic expect_o(input string nm,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] b, input logic hz,
                          input logic dn, input logic chk);
    exp_t x;
    x.name = nm; x.cyc = cyc;
    x.d0 = d0; x.d1 = d1; x.b = b;
    x.hz = hz; x.dn = dn; x.chk = chk;
    q.push_back(x);
  endtask

  task automatic init_run(input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 30) drive(10, 11, 0, 0, 0, 0, 0);
      expect_o(nm, 0, 0, 2'b00, k < 31, k == 31, k == 31);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    expect_o("reset", 0, 0, 2'b00, 1, 0, 1);
    step();

    // traffic during INIT must be ignored
    rst = 1'b0;
    drive(3, 4, 1, 4, 1, 3, 32'h0000_FFFF);
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 30) drive(3, 4, 0, 0, 0, 0, 0);
      expect_o(k < 31 ? "init" : "init_done",
               0, 0, 2'b00, k < 31, k == 31, k == 31);
    end

    for (int r = 1; r < 32; r++) begin
      drive(5'(r), 5'(32 - r), 0, 0, 0, 0, 0);
      expect_o("clear_read", 0, 0, 2'b00, 0, 1, 1);
      step();
    end

    drive(5, 5, 1, 5, 0, 0, 0);
    expect_o("iss5_pre", 0, 0, 2'b00, 0, 1, 1);
    step();
    drive(5, 5, 0, 0, 0, 0, 0);
    expect_o("busy5_c1", 0, 0, 2'b11, 1, 1, 1);
    step();
    expect_o("busy5_c2", 0, 0, 2'b11, 1, 1, 1);
    step();
    drive(5, 5, 0, 0, 1, 5, 32'hDEAD_BEEF);
    expect_o("wb5", BYP ? 32'hDEAD_BEEF : 32'h0,
             BYP ? 32'hDEAD_BEEF : 32'h0,
             BYP ? 2'b00 : 2'b11, !BYP, 1, 1);
    step();
    drive(5, 5, 0, 0, 0, 0, 0);
    expect_o("x5_after", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0, 1, 1);
    step();

    drive(7, 0, 1, 7, 1, 7, 32'h77);
    expect_o("iw7_same", BYP ? 32'h77 : 32'h0, 0, 2'b00, 0, 1, 1);
    step();
    drive(7, 0, 0, 0, 0, 0, 0);
    expect_o("busy7_kept", 32'h77, 0, 2'b01, 1, 1, 1);
    step();
    drive(7, 0, 0, 0, 1, 7, 32'h78);
    expect_o("wb7", BYP ? 32'h78 : 32'h77, 0,
             BYP ? 2'b00 : 2'b01, !BYP, 1, 1);
    step();
    drive(7, 0, 0, 0, 0, 0, 0);
    expect_o("x7_after", 32'h78, 0, 2'b00, 0, 1, 1);
    step();

    drive(0, 0, 1, 0, 1, 0, 32'h1234);
    expect_o("x0_wb", 0, 0, 2'b00, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_o("x0_after", 0, 0, 2'b00, 0, 1, 1);
    step();

    drive(9, 0, 0, 0, 1, 9, 32'h11);
    step();
    drive(9, 0, 1, 9, 0, 0, 0);
    expect_o("x9_pre", 32'h11, 0, 2'b00, 0, 1, 1);
    step();
    drive(9, 0, 0, 0, 1, 9, 32'hA5A5_A5A5);
    expect_o("x9_byp", BYP ? 32'hA5A5_A5A5 : 32'h11, 0,
             BYP ? 2'b00 : 2'b01, !BYP, 1, 1);
    step();
    drive(9, 0, 0, 0, 0, 0, 0);
    expect_o("x9_after", 32'hA5A5_A5A5, 0, 2'b00, 0, 1, 1);
    step();

    drive(10, 11, 1, 10, 0, 0, 0);
    step();
    drive(10, 11, 1, 11, 0, 0, 0);
    step();
    drive(10, 11, 0, 0, 0, 0, 0);
    expect_o("busy10_11", 0, 0, 2'b11, 1, 1, 1);
    step();

    rst = 1'b1;
    expect_o("rst_mid_op", 0, 0, 2'b00, 1, 0, 0);
    step();
    rst = 1'b0;
    init_run(10, "init_part");
    rst = 1'b1;
    expect_o("rst_mid_init", 0, 0, 2'b00, 1, 0, 0);
    step();
    rst = 1'b0;
    init_run(31, "reinit");

    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_regfile_sb.md
ID_REGFILE_SB -- requirements
Module: id_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=4).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rd_addr  in  NRD x log2(NREG)  read addresses (port 0 = rs1, port 1 = rs2).
REQ-007 SHALL have port rd_data  out  NRD x XLEN  read data.
REQ-008 SHALL have port rd_busy  out  NRD  read register has a write pending.
REQ-009 SHALL have port hazard  out  1  OR of rd_busy, or init in progress; decode stall request.
REQ-010 SHALL have port issue_valid  in  1  instruction leaving decode this cycle.
REQ-011 SHALL have port issue_we  in  1  issued instruction writes a register.
REQ-012 SHALL have port issue_rd  in  log2(NREG)  issued destination register.
REQ-013 SHALL have port wb_valid  in  1  writeback write enable.
REQ-014 SHALL have port wb_rd  in  log2(NREG)  writeback destination.
REQ-015 SHALL have port wb_data  in  XLEN  writeback data.
REQ-016 SHALL have port init_done  out  1  register clear sequence complete.

Function
REQ-017 SHALL implement FSM states INIT and READY; INIT clears one register per cycle, index 1..NREG-1, via a counter, then transitions to READY (NREG-1 cycles after reset deasserts).
REQ-018 SHALL, in INIT, hold init_done=0 and hazard=1, and ignore issue_valid and wb_valid.
REQ-019 SHALL, in READY, hold init_done=1.
REQ-020 SHALL combinationally return register contents on rd_data; address 0 SHALL read 0 and never be busy.
REQ-021 SHALL write wb_data to wb_rd on a clock edge when wb_valid=1 and wb_rd!=0; writes to x0 are dropped.
REQ-022 SHALL set busy[issue_rd] on an edge when issue_valid=1, issue_we=1, and issue_rd!=0.
REQ-023 SHALL clear busy[wb_rd] on an edge when wb_valid=1.
REQ-024 SHALL give set priority when issue and wb target the same register in one cycle (busy remains 1).
REQ-025 SHALL compute rd_busy[i] = busy[rd_addr[i]] (subject to REQ-030); hazard = |rd_busy or state==INIT.
REQ-026 SHALL allow at most one outstanding writer per register; a second issue to a busy register keeps busy=1 (no counting).

Reset
REQ-027 SHALL, on rst=1 at an edge, clear all busy bits, reset the clear counter to 1, and enter INIT, including mid-INIT or mid-operation.
REQ-028 SHALL, while in reset, drive init_done=0, hazard=1, and rd_busy=0; rd_data is undefined until INIT completes, except for x0.

Configuration
REQ-029 SHALL use macro ID_REGFILE_BYPASS_EN to select write-through forwarding.
REQ-030 SHALL, with ID_REGFILE_BYPASS_EN defined, drive rd_data[i]=wb_data and rd_busy[i]=0 in the same cycle when wb_valid=1, wb_rd==rd_addr[i], and rd_addr[i]!=0.
REQ-031 SHALL, without ID_REGFILE_BYPASS_EN, show the written value only on the cycle after the write edge; busy clears at that edge.

Structure
REQ-032 SHALL place the state enum (INIT, READY) and the default XLEN/NREG constants in shared package rv32_pkg.
REQ-033 SHALL isolate storage and write logic in sub-module rf_bank (NREG x XLEN, 1 write port, NRD async read ports); FSM, scoreboard, and bypass stay in id_regfile_sb.

Verification
REQ-034 SHALL cover: reset pulse then 31 cycles -> init_done rises on cycle 31; all reads of x1..x31 return 0.
REQ-035 SHALL cover: issue rd=5, then 3 cycles later wb rd=5 data=0xDEADBEEF -> rd_busy for x5 is 1 for 3 cycles and rd_data=0xDEADBEEF afterward.
REQ-036 SHALL cover: same-cycle issue rd=7 and wb rd=7 -> busy[7] stays 1.
REQ-037 SHALL cover: wb rd=0 data=0x1234 -> x0 still reads 0 and is never busy.
REQ-038 SHALL cover: with BYPASS_EN, read x9 while wb rd=9 data=0xA5A5A5A5 -> same-cycle rd_data=0xA5A5A5A5 and hazard=0; without it -> old value and hazard=1.
REQ-039 SHALL cover: rst asserted at cycle 10 of INIT and with busy bits set -> all busy bits clear and INIT restarts with a full NREG-1 cycle sequence.
